// File: rtl/mv_pattern6_check_if.sv
// Video stream bundle between a pattern source and the border-pattern checker.
// hs_q is the checker's one-cycle-delayed copy of hs, exposed as a sync monitor tap.
interface mv_pattern6_check_if;
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] rgb_r;
    logic [7:0] rgb_g;
    logic [7:0] rgb_b;
    logic       hs_q;

    modport master (output hs, vs, de, rgb_r, rgb_g, rgb_b, input hs_q);
    modport slave  (input hs, vs, de, rgb_r, rgb_g, rgb_b, output hs_q);
endinterface

// File: rtl/mv_pattern6_check.sv
// Locks onto a video stream of known geometry and checks a white-border / black-interior
// test pattern, counting mismatching pixels and reporting per-frame pass/fail.
module mv_pattern6_check #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mv_pattern6_check_if.slave vid,
    input  logic [15:0]      hactive,
    input  logic [15:0]      vactive,
    input  logic             clr,
    output logic             locked,
    output logic             frame_done,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      meas_h,
    output logic [15:0]      meas_v
);

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK} state_t;

    state_t      state, state_nxt;
    logic        vs_d, de_d, hs_d;
    logic [15:0] x_cnt, y_cnt;
    logic        pix_flag, geom_flag;

    logic        vs_rise, de_fall, line_bad, geom_close, pix_bad, border;
    logic [15:0] px, py, h_last, v_last;
    logic [7:0]  exp_px;

    assign vs_rise    = vid.vs & ~vs_d;
    assign de_fall    = ~vid.de & de_d;
    assign line_bad   = de_fall && (x_cnt != hactive);
    // A line ending in the same cycle as vs_rise still belongs to the closing frame.
    assign geom_close = geom_flag | line_bad | (y_cnt != vactive);

    // A pixel coinciding with vs_rise is (0,0) of the new frame.
    assign px      = vs_rise ? 16'd0 : x_cnt;
    assign py      = vs_rise ? 16'd0 : y_cnt;
    assign h_last  = hactive - 16'd1;
    assign v_last  = vactive - 16'd1;
    assign border  = (px == 16'd0) || (py == 16'd0) || (px == h_last) || (py == v_last);
    assign exp_px  = border ? 8'hFF : 8'h00;
    assign pix_bad = (state == CHECK) && vid.de &&
                     ((vid.rgb_r != exp_px) || (vid.rgb_g != exp_px) || (vid.rgb_b != exp_px));

    assign vid.hs_q = hs_d;

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (vs_rise) state_nxt = MEASURE;
            MEASURE: if (vs_rise && !geom_close && (hactive != 16'd0) && (vactive != 16'd0))
                         state_nxt = CHECK;
            CHECK:   if (vs_rise && geom_close) state_nxt = MEASURE;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
            locked <= 1'b0;
        end else begin
            state <= state_nxt;
            locked <= (state_nxt == CHECK);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d      <= 1'b0;
            de_d      <= 1'b0;
            hs_d      <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            meas_h    <= '0;
            meas_v    <= '0;
            geom_flag <= 1'b0;
            pix_flag  <= 1'b0;
        end else begin
            vs_d <= vid.vs;
            de_d <= vid.de;
            hs_d <= vid.hs;

            if (vid.de)
                x_cnt <= (px == 16'hFFFF) ? px : px + 16'd1;
            else if (de_fall || vs_rise)
                x_cnt <= '0;

            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall && (y_cnt != 16'hFFFF))
                y_cnt <= y_cnt + 16'd1;

            if (de_fall) meas_h <= x_cnt;
            if (vs_rise) meas_v <= y_cnt;

            if (vs_rise)       geom_flag <= 1'b0;
            else if (line_bad) geom_flag <= 1'b1;

            if (vs_rise)      pix_flag <= pix_bad;
            else if (pix_bad) pix_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= vs_rise && (state == CHECK);
            if (vs_rise && (state == CHECK))
                frame_err <= pix_flag | geom_close;

            if (clr)
                err_cnt <= '0;
            else if (pix_bad && (err_cnt != {ERR_W{1'b1}}))
                err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};

            if (clr)
                frame_cnt <= '0;
            else if (vs_rise && (state == CHECK))
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mv_pattern6_check.sv
// Directed bench for mv_pattern6_check: lock-up, pixel/geometry errors, saturation, clr, reset, hactive=0.
module tb_mv_pattern6_check;
    localparam int H = 16;
    localparam int V = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] hactive, vactive;
    logic        clr;
    logic        locked, frame_done, frame_err;
    logic [3:0]  err_cnt;
    logic [15:0] frame_cnt, meas_h, meas_v;

    int n_chk = 0;
    int n_pass = 0;
    logic lk_seen, done_seen;
    logic fd, fe;
    logic [3:0] err_at;

    mv_pattern6_check_if vid();

    mv_pattern6_check #(.ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .vid(vid),
        .hactive(hactive), .vactive(vactive), .clr(clr),
        .locked(locked), .frame_done(frame_done), .frame_err(frame_err),
        .err_cnt(err_cnt), .frame_cnt(frame_cnt), .meas_h(meas_h), .meas_v(meas_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (locked) lk_seen = 1'b1;
        if (frame_done) done_seen = 1'b1;
    endtask

    task automatic line(input int y, input int len, input int cx, input int cy,
                        input bit bad_all, input bit clr_px);
        logic [7:0] v;
        for (int x = 0; x < len; x++) begin
            v = (x == 0 || y == 0 || x == H - 1 || y == V - 1) ? 8'hFF : 8'h00;
            vid.rgb_r = v; vid.rgb_g = v; vid.rgb_b = v;
            if (bad_all && v == 8'h00) vid.rgb_g = 8'h5A;
            if (x == cx && y == cy) begin
                vid.rgb_r = 8'h01;
                clr = clr_px;
            end
            vid.de = 1'b1;
            tick();
            clr = 1'b0;
            if (x == cx && y == cy) err_at = err_cnt;
        end
        vid.de = 1'b0;
        vid.rgb_r = 8'h00; vid.rgb_g = 8'h00; vid.rgb_b = 8'h00;
        vid.hs = 1'b1;
        tick();
        vid.hs = 1'b0;
        repeat (3) tick();
    endtask

    task automatic vs_pulse();
        vid.vs = 1'b1;
        tick();
        fd = frame_done;
        fe = frame_err;
        tick();
        vid.vs = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame(input int cx, input int cy, input bit bad_all,
                         input bit clr_px, input int short_y);
        for (int y = 0; y < V; y++)
            line(y, (y == short_y) ? H - 1 : H, cx, cy, bad_all, clr_px);
        vs_pulse();
    endtask

    initial begin
        rst_n = 1'b0; hactive = 16'(H); vactive = 16'(V); clr = 1'b0;
        vid.hs = 1'b0; vid.vs = 1'b0; vid.de = 1'b0;
        vid.rgb_r = 8'h00; vid.rgb_g = 8'h00; vid.rgb_b = 8'h00;
        lk_seen = 1'b0; done_seen = 1'b0; fd = 1'b0; fe = 1'b0; err_at = 4'h0;
        repeat (3) tick();
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_meas_h", meas_h, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        tick();

        // frames 1-3: lock-up then first checked frame
        frame(-1, -1, 0, 0, -1);
        chk("f1_locked", locked, 0);
        frame(-1, -1, 0, 0, -1);
        chk("f2_locked", locked, 1);
        chk("f2_no_done", fd, 0);
        frame(-1, -1, 0, 0, -1);
        chk("f3_done", fd, 1);
        chk("f3_err", fe, 0);
        chk("f3_err_cnt", err_cnt, 0);
        chk("f3_frame_cnt", frame_cnt, 1);
        chk("f3_meas_h", meas_h, 16);
        chk("f3_meas_v", meas_v, 8);

        // single corrupted pixel (5,3)
        frame(5, 3, 0, 0, -1);
        chk("f4_err_at_px", err_at, 1);
        chk("f4_done", fd, 1);
        chk("f4_frame_err", fe, 1);
        chk("f4_frame_cnt", frame_cnt, 2);
        chk("f4_locked", locked, 1);

        // short line drops lock, one clean frame re-locks
        frame(-1, -1, 0, 0, 2);
        chk("f5_done", fd, 1);
        chk("f5_frame_err", fe, 1);
        chk("f5_locked", locked, 0);
        chk("f5_frame_cnt", frame_cnt, 3);
        frame(-1, -1, 0, 0, -1);
        chk("f6_no_done", fd, 0);
        chk("f6_relocked", locked, 1);
        frame(-1, -1, 0, 0, -1);
        chk("f7_done", fd, 1);
        chk("f7_frame_err", fe, 0);
        chk("f7_frame_cnt", frame_cnt, 4);

        // saturation: 84 interior errors on top of 1
        frame(-1, -1, 1, 0, -1);
        chk("f8_err_sat", err_cnt, 15);
        chk("f8_frame_cnt", frame_cnt, 5);
        chk("f8_locked", locked, 1);

        // clr in the same cycle as an error
        frame(5, 3, 0, 1, -1);
        chk("f9_clr_at_px", err_at, 0);
        chk("f9_err_cnt", err_cnt, 0);
        chk("f9_frame_err", fe, 1);
        chk("f9_frame_cnt", frame_cnt, 1);

        // reset mid-frame while locked
        for (int y = 0; y < 3; y++) line(y, H, -1, -1, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_meas_h", meas_h, 0);
        chk("mid_rst_meas_v", meas_v, 0);
        chk("mid_rst_done", frame_done, 0);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int y = 3; y < V; y++) line(y, H, -1, -1, 0, 0);
        vs_pulse();
        chk("post_rst_no_done", done_seen, 0);
        chk("post_rst_locked", locked, 0);
        frame(-1, -1, 0, 0, -1);
        chk("post_rst_relock", locked, 1);
        chk("post_rst_no_done2", fd, 0);
        frame(-1, -1, 0, 0, -1);
        chk("post_rst_done", fd, 1);
        chk("post_rst_frame_cnt", frame_cnt, 1);

        // hactive = 0 never locks
        hactive = 16'd0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lk_seen = 1'b0; done_seen = 1'b0;
        repeat (5) frame(-1, -1, 0, 0, -1);
        chk("h0_never_locked", lk_seen, 0);
        chk("h0_no_done", done_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
